sar_search_ctrl: RTL and testbench

- Sequential successive-approximation controller for a magnitude comparator: it drives a trial value into the comparator's A input and reads back the three result flags.
- It binary-searches for the unknown value on the comparator's B input, one compare per clock.
- The three flags are assumed to describe `trial` versus target.
- Result is reported with a one-cycle `done` pulse and a found/error status.

---
 rtl/sar_search_ctrl.sv | 130 +++++++++++++
 tb/tb_sar_search_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - successive-approximation search controller driving a magnitude comparator
// Optional build macro: SAR_EARLY_EXIT_EN (finish on the first cmp_eq instead of running all WIDTH compares).
module sar_search_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cmp_gt,
  input  logic                       cmp_eq,
  input  logic                       cmp_lt,
  output logic [WIDTH-1:0]           trial,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       found,
  output logic                       err,
  output logic [$clog2(WIDTH):0]     cycles
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] trial_d, result_d, step_trial;
  logic [CW-1:0]    cycles_d;
  logic             busy_d, done_d, found_d, err_d;
  logic             hit_q, hit_d, hit_next, flags_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      trial   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      found   <= 1'b0;
      err     <= 1'b0;
      cycles  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      trial   <= trial_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      found   <= found_d;
      err     <= err_d;
      cycles  <= cycles_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    trial_d    = trial;
    busy_d     = busy;
    done_d     = 1'b0;
    result_d   = result;
    found_d    = found;
    err_d      = err;
    cycles_d   = cycles;
    hit_d      = hit_q;
    flags_ok   = $onehot({cmp_gt, cmp_eq, cmp_lt});
    hit_next   = hit_q | cmp_eq;
    // Current bit decision: a "greater" answer means this bit overshoots the target.
    step_trial = trial;
    if (cmp_gt) step_trial[idx_q] = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEARCH;
          idx_d    = IW'(WIDTH - 1);
          trial_d  = {1'b1, {(WIDTH-1){1'b0}}};
          busy_d   = 1'b1;
          cycles_d = '0;
          hit_d    = 1'b0;
        end
      end
      SEARCH: begin
        cycles_d = cycles + 1'b1;
        if (!flags_ok) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          result_d = '0;
          found_d  = 1'b0;
        end else if (EARLY_EXIT && cmp_eq) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = trial;
          found_d  = 1'b1;
          hit_d    = 1'b1;
        end else if (idx_q == '0) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          trial_d  = step_trial;
          result_d = step_trial;
          found_d  = hit_next;
          hit_d    = hit_next;
        end else begin
          step_trial[idx_q - 1'b1] = 1'b1;
          trial_d = step_trial;
          idx_d   = idx_q - 1'b1;
          hit_d   = hit_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - directed self-checking bench for sar_search_ctrl
// Compile with SAR_EARLY_EXIT_EN to check the early-exit build.
module tb_sar_search_ctrl;

  localparam int WIDTH = 8;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cmp_gt, cmp_eq, cmp_lt;
  logic [WIDTH-1:0] trial, result;
  logic             busy, done, found, err;
  logic [3:0]       cycles;

  logic [WIDTH-1:0] target = '0;
  logic             force_bad = 1'b0;

  int total = 0;
  int bad = 0;
  int unsigned seq[$];

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .trial(trial), .busy(busy), .done(done), .result(result),
    .found(found), .err(err), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Comparator model: flags describe trial versus the bench's target.
  always_comb begin
    cmp_gt = !force_bad && (trial > target);
    cmp_eq = !force_bad && (trial == target);
    cmp_lt = !force_bad && (trial < target);
  end

  typedef struct {
    int unsigned tgt;
    int unsigned exp_result;
    bit          exp_found;
    int unsigned exp_cycles_full;
    int unsigned exp_cycles_early;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the start edge.
  task automatic do_start(input int unsigned t);
    target = t[WIDTH-1:0];
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Records trial per compare; optional start pulse at a given compare index.
  task automatic wait_done(input int pulse_at, output int n);
    seq.delete();
    seq.push_back(trial);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k - 1 == pulse_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        n = k;
        break;
      end
      seq.push_back(trial);
    end
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done expected done within 20 edges");
    end
  endtask

  initial begin
    int n;
    int unsigned exp_n;
    vecs[0] = '{170, 170, 1'b1, 8, 7};
    vecs[1] = '{0,   0,   1'b0, 8, 8};
    vecs[2] = '{255, 255, 1'b1, 8, 8};
    vecs[3] = '{1,   1,   1'b1, 8, 8};
    vecs[4] = '{128, 128, 1'b1, 8, 1};
    vecs[5] = '{85,  85,  1'b1, 8, 8};
    vecs[6] = '{254, 254, 1'b1, 8, 7};

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_trial", trial, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_cycles", cycles, 0);

    // Target 170 with full trial sequence
    do_start(170);
    chk("start_busy", busy, 1);
    chk("start_cycles", cycles, 0);
    wait_done(-1, n);
    exp_n = EARLY ? 7 : 8;
    chk("t170_latency", n, exp_n);
    chk("t170_seqlen", seq.size(), exp_n);
    begin
      int unsigned exp_seq[8] = '{128, 192, 160, 176, 168, 172, 170, 171};
      for (int i = 0; i < 8; i++)
        if (i < seq.size()) chk($sformatf("t170_trial%0d", i), seq[i], exp_seq[i]);
    end
    chk("t170_result", result, 170);
    chk("t170_found", found, 1);
    chk("t170_cycles", cycles, exp_n);
    chk("t170_err", err, 0);
    chk("t170_busy", busy, 0);
    @(negedge clk);
    chk("t170_done_width", done, 0);
    chk("t170_result_hold", result, 170);

    // Table-driven searches
    for (int v = 0; v < 7; v++) begin
      exp_n = EARLY ? vecs[v].exp_cycles_early : vecs[v].exp_cycles_full;
      do_start(vecs[v].tgt);
      wait_done(-1, n);
      chk($sformatf("vec%0d_latency", v), n, exp_n);
      chk($sformatf("vec%0d_result", v), result, vecs[v].exp_result);
      chk($sformatf("vec%0d_found", v), found, vecs[v].exp_found);
      chk($sformatf("vec%0d_cycles", v), cycles, exp_n);
      chk($sformatf("vec%0d_err", v), err, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_low", v), done, 0);
    end

    // Back-to-back: target 0 then 255 with start held in the done cycle
    do_start(0);
    wait_done(-1, n);
    chk("b2b0_latency", n, 8);
    for (int i = 0; i < 8; i++)
      if (i < seq.size()) chk($sformatf("b2b0_trial%0d", i), seq[i], 128 >> i);
    chk("b2b0_result", result, 0);
    chk("b2b0_found", found, 0);
    do_start(255);
    chk("b2b255_busy", busy, 1);
    chk("b2b255_trial0", trial, 128);
    wait_done(-1, n);
    chk("b2b255_latency", n, 8);
    chk("b2b255_result", result, 255);
    chk("b2b255_found", found, 1);
    chk("b2b255_cycles", cycles, 8);
    @(negedge clk);

    // Invalid flags on the 3rd compare
    do_start(100);
    @(negedge clk);
    @(negedge clk);
    force_bad = 1'b1;
    @(negedge clk);
    force_bad = 1'b0;
    chk("bad_done", done, 1);
    chk("bad_err", err, 1);
    chk("bad_result", result, 0);
    chk("bad_found", found, 0);
    chk("bad_cycles", cycles, 3);
    chk("bad_busy", busy, 0);
    @(negedge clk);
    chk("bad_done_low", done, 0);
    do_start(42);
    wait_done(-1, n);
    chk("after_bad_err", err, 0);
    chk("after_bad_result", result, 42);
    @(negedge clk);

    // Start pulsed at compare 4 is ignored
    do_start(85);
    wait_done(3, n);
    chk("ign_latency", n, 8);
    chk("ign_result", result, 85);
    chk("ign_found", found, 1);
    chk("ign_cycles", cycles, 8);
    @(negedge clk);
    chk("ign_no_restart", busy, 0);

    // Asynchronous reset at compare 5
    do_start(200);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_trial", trial, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("arst_no_done", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
